// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register bank: byte offsets of each
// register inside the bank window and the edge-detect arming delay.
package gpio_pkg;

    localparam logic [4:0] OFF_DOUT  = 5'h00;
    localparam logic [4:0] OFF_DIR   = 5'h04;
    localparam logic [4:0] OFF_DIN   = 5'h08;
    localparam logic [4:0] OFF_IEN   = 5'h0C;
    localparam logic [4:0] OFF_IPOL  = 5'h10;
    localparam logic [4:0] OFF_ISTAT = 5'h14;
    localparam logic [4:0] OFF_SET   = 5'h18;
    localparam logic [4:0] OFF_CLR   = 5'h1C;

    // Cycles after reset release before edge detection is trusted
    // (the synchroniser and the one-cycle delay stage must be full).
    localparam logic [1:0] ARM_CYCLES = 2'd3;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous pin inputs, cleared to 0 on reset.
module gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two back-to-back flops to let metastability resolve before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Memory-mapped GPIO bank: data/direction registers with atomic set/clear,
// synchronised input readback and sticky edge-detect interrupts with
// per-bit polarity. Decodes its own eight-word window at BASE_ADDR.
module gpio_bank_ctrl
    import gpio_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    GPIO_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h10010024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_ram,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    logic [ADDR_WIDTH-1:0] off_s;
    logic [4:0]            reg_off_s;
    logic                  hit_s;
    logic                  wr_s;
    logic                  rd_s;
    logic [GPIO_WIDTH-1:0] wmask_s;
    logic                  unused_wdata_s;

    logic [GPIO_WIDTH-1:0] dout_r;
    logic [GPIO_WIDTH-1:0] dir_r;
    logic [GPIO_WIDTH-1:0] ien_r;
    logic [GPIO_WIDTH-1:0] ipol_r;
    logic [GPIO_WIDTH-1:0] istat_r;
    logic [GPIO_WIDTH-1:0] istat_next_s;
    logic [GPIO_WIDTH-1:0] w1c_s;
    logic [GPIO_WIDTH-1:0] edge_s;
    logic [GPIO_WIDTH-1:0] din_s;
    logic [GPIO_WIDTH-1:0] din_d_r;
    logic [1:0]            arm_cnt_r;
    logic                  irq_r;
    logic [GPIO_WIDTH-1:0] rd_val_s;
    logic [DATA_WIDTH-1:0] rdata_next_s;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rdata_valid_r;

    // Window decode: BASE_ADDR need not be 32-byte aligned, so subtract first.
    assign off_s          = addr_ram - BASE_ADDR;
    assign reg_off_s      = off_s[4:0];
    assign hit_s          = (off_s[ADDR_WIDTH-1:5] == {(ADDR_WIDTH-5){1'b0}}) &&
                            (off_s[1:0] == 2'b00);
    assign wr_s           = we & hit_s;
    assign rd_s           = re & hit_s;
    assign wmask_s        = wdata[GPIO_WIDTH-1:0];
    assign unused_wdata_s = ^wdata;

    gpio_sync #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_in),
        .q     (din_s)
    );

    // One-cycle delayed copy of the synchronised inputs and the arming counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_d_r   <= {GPIO_WIDTH{1'b0}};
            arm_cnt_r <= 2'd0;
        end else begin
            din_d_r <= din_s;
            if (arm_cnt_r != ARM_CYCLES) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
        end
    end

    // Edge detect with per-bit polarity; ISTAT set beats a same-cycle w1c.
    always_comb begin
        edge_s       = {GPIO_WIDTH{1'b0}};
        w1c_s        = {GPIO_WIDTH{1'b0}};
        if (arm_cnt_r == ARM_CYCLES) begin
            edge_s = (ipol_r & din_d_r & ~din_s) | (~ipol_r & din_s & ~din_d_r);
        end else begin
            edge_s = {GPIO_WIDTH{1'b0}};
        end
        if (wr_s && (reg_off_s == OFF_ISTAT)) begin
            w1c_s = wmask_s;
        end else begin
            w1c_s = {GPIO_WIDTH{1'b0}};
        end
        istat_next_s = (istat_r & ~w1c_s) | edge_s;
    end

    // Register file writes, sticky status and registered interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r  <= {GPIO_WIDTH{1'b0}};
            dir_r   <= {GPIO_WIDTH{1'b0}};
            ien_r   <= {GPIO_WIDTH{1'b0}};
            ipol_r  <= {GPIO_WIDTH{1'b0}};
            istat_r <= {GPIO_WIDTH{1'b0}};
            irq_r   <= 1'b0;
        end else begin
            if (wr_s) begin
                case (reg_off_s)
                    OFF_DOUT: dout_r <= wmask_s;
                    OFF_DIR:  dir_r  <= wmask_s;
                    OFF_IEN:  ien_r  <= wmask_s;
                    OFF_IPOL: ipol_r <= wmask_s;
                    OFF_SET:  dout_r <= dout_r | wmask_s;
                    OFF_CLR:  dout_r <= dout_r & ~wmask_s;
                    default:  dout_r <= dout_r;
                endcase
            end
            istat_r <= istat_next_s;
            irq_r   <= |(istat_r & ien_r);
        end
    end

    // Read mux: pre-write register values; SET/CLR and DIN-writes read plainly.
    always_comb begin
        rd_val_s     = {GPIO_WIDTH{1'b0}};
        rdata_next_s = {DATA_WIDTH{1'b0}};
        case (reg_off_s)
            OFF_DOUT:  rd_val_s = dout_r;
            OFF_DIR:   rd_val_s = dir_r;
            OFF_DIN:   rd_val_s = din_s;
            OFF_IEN:   rd_val_s = ien_r;
            OFF_IPOL:  rd_val_s = ipol_r;
            OFF_ISTAT: rd_val_s = istat_r;
            default:   rd_val_s = {GPIO_WIDTH{1'b0}};
        endcase
        rdata_next_s[GPIO_WIDTH-1:0] = rd_val_s;
    end

    // Registered read data; holds between reads, valid pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r       <= {DATA_WIDTH{1'b0}};
            rdata_valid_r <= 1'b0;
        end else begin
            if (rd_s) begin
                rdata_r <= rdata_next_s;
            end else begin
                rdata_r <= rdata_r;
            end
            rdata_valid_r <= rd_s;
        end
    end

    assign sel         = hit_s;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign gpio_out    = dout_r;
    assign gpio_oe     = dir_r;
    assign irq         = irq_r;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Self-checking bench for gpio_bank_ctrl: a register-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_gpio_bank_ctrl;

    localparam logic [31:0] BASE = 32'h10010024;

    logic        clk;
    logic        reset;
    logic [31:0] addr_ram;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        sel;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    gpio_bank_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .GPIO_WIDTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_ram    (addr_ram),
        .wdata       (wdata),
        .we          (we),
        .re          (re),
        .sel         (sel),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 32) && ((off % 4) == 0);
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]  m_dout, m_dir, m_ien, m_ipol, m_istat;
    logic [31:0] m_rdata;
    logic        m_rv, m_irq;
    logic [7:0]  samp [3];      // pin samples taken at the last three edges
    int          edges_since_rst;
    bit          started = 1'b0;

    always @(posedge clk) begin
        logic [7:0] seen, seen_old, events, w, val, nxt_istat;
        logic       nxt_irq;
        int         off;
        if (reset) begin
            m_dout = 8'h00; m_dir = 8'h00; m_ien = 8'h00; m_ipol = 8'h00; m_istat = 8'h00;
            m_rdata = 32'h0; m_rv = 1'b0; m_irq = 1'b0;
            for (int i = 0; i < 3; i++) samp[i] = 8'h00;
            edges_since_rst = 0;
            started = 1'b1;
        end else begin
            seen     = samp[1];   // pin value as visible in DIN right now
            seen_old = samp[2];   // the visible value one cycle earlier
            events   = 8'h00;
            if (edges_since_rst >= 3) begin
                for (int i = 0; i < 8; i++)
                    events[i] = m_ipol[i] ? (seen_old[i] && !seen[i]) : (seen[i] && !seen_old[i]);
            end
            edges_since_rst++;
            off = int'(addr_ram - BASE);
            w   = wdata[7:0];
            nxt_irq   = |(m_istat & m_ien);
            nxt_istat = m_istat;
            m_rv = re && model_hit(addr_ram);
            if (m_rv) begin
                case (off)
                    0:  val = m_dout;
                    4:  val = m_dir;
                    8:  val = seen;
                    12: val = m_ien;
                    16: val = m_ipol;
                    20: val = m_istat;
                    default: val = 8'h00;
                endcase
                m_rdata = {24'h0, val};
            end
            if (we && model_hit(addr_ram)) begin
                case (off)
                    0:  m_dout = w;
                    4:  m_dir  = w;
                    12: m_ien  = w;
                    16: m_ipol = w;
                    20: nxt_istat = m_istat & ~w;
                    24: m_dout = m_dout | w;
                    28: m_dout = m_dout & ~w;
                    default: ;
                endcase
            end
            m_istat = nxt_istat | events;
            m_irq   = nxt_irq;
            samp[2] = samp[1];
            samp[1] = samp[0];
            samp[0] = gpio_in;
        end
        #1;
        if (started) begin
            chk("gpio_out", {24'h0, gpio_out}, {24'h0, m_dout});
            chk("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            chk("rdata_valid", {31'h0, rdata_valid}, {31'h0, m_rv});
            chk("rdata", rdata, m_rdata);
            chk("sel", {31'h0, sel}, {31'h0, model_hit(addr_ram)});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr_ram = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr_ram = 32'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr_ram = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0; addr_ram = 32'h0;
        d = rdata; v = rdata_valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] d;
        logic        v;
        int          cnt;

        reset = 1'b1; addr_ram = 32'h0; wdata = 32'h0; we = 1'b0; re = 1'b0;
        gpio_in = 8'hFF;

        // 1: pins high through reset give no spurious status; DIN follows pins
        idle(3);
        reset = 1'b0;
        idle(10);
        bus_read(BASE + 32'h14, d, v);
        chk("t1_istat", d, 32'h0);
        chk("t1_irq", {31'h0, irq}, 32'h0);
        bus_read(BASE + 32'h08, d, v);
        chk("t1_din", d, 32'h0000_00FF);
        chk("t1_din_valid", {31'h0, v}, 32'h1);

        // 2: DOUT write then SET then CLR on consecutive edges
        @(negedge clk);
        addr_ram = BASE; wdata = 32'h0F; we = 1'b1;
        @(negedge clk);
        chk("t2_dout", {24'h0, gpio_out}, 32'h0F);
        addr_ram = BASE + 32'h18; wdata = 32'hF0;
        @(negedge clk);
        chk("t2_set", {24'h0, gpio_out}, 32'hFF);
        addr_ram = BASE + 32'h1C; wdata = 32'h03;
        @(negedge clk);
        chk("t2_clr", {24'h0, gpio_out}, 32'hFC);
        we = 1'b0; addr_ram = 32'h0; wdata = 32'h0;
        bus_read(BASE, d, v);
        chk("t2_read", d, 32'hFC);
        chk("t2_valid", {31'h0, v}, 32'h1);
        @(negedge clk);
        chk("t2_valid_drop", {31'h0, rdata_valid}, 32'h0);

        // 3: rising edge on pin 0, interrupt, then w1c
        gpio_in = 8'h00;
        idle(5);
        bus_write(BASE + 32'h0C, 32'h01);
        @(negedge clk);
        gpio_in = 8'h01;
        cnt = 0;
        while (cnt < 8 && irq !== 1'b1) begin
            @(negedge clk);
            cnt++;
        end
        chk("t3_irq_latency", cnt, 32'd4);
        bus_read(BASE + 32'h14, d, v);
        chk("t3_istat", d, 32'h01);
        bus_write(BASE + 32'h14, 32'h01);
        chk("t3_irq_still", {31'h0, irq}, 32'h1);
        @(negedge clk);
        chk("t3_irq_drop", {31'h0, irq}, 32'h0);

        // 4: falling-edge polarity on pin 3 with the interrupt masked
        bus_write(BASE + 32'h10, 32'h08);
        bus_write(BASE + 32'h0C, 32'h00);
        gpio_in = 8'h09;
        idle(5);
        bus_read(BASE + 32'h14, d, v);
        chk("t4_no_rise", d, 32'h00);
        gpio_in = 8'h01;
        idle(5);
        bus_read(BASE + 32'h14, d, v);
        chk("t4_istat", d, 32'h08);
        chk("t4_irq_masked", {31'h0, irq}, 32'h0);
        bus_write(BASE + 32'h0C, 32'h08);
        @(negedge clk);
        chk("t4_irq", {31'h0, irq}, 32'h1);

        // 5: w1c and a new rising edge on pin 0 in the same cycle
        bus_write(BASE + 32'h14, 32'hFF);
        bus_write(BASE + 32'h0C, 32'h00);
        gpio_in = 8'h00;
        idle(5);
        @(negedge clk);
        gpio_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        addr_ram = BASE + 32'h14; wdata = 32'h01; we = 1'b1;
        @(negedge clk);
        we = 1'b0; addr_ram = 32'h0; wdata = 32'h0;
        bus_read(BASE + 32'h14, d, v);
        chk("t5_set_wins", d, 32'h01);

        // 6: out-of-window and misaligned accesses have no effect
        @(negedge clk);
        addr_ram = BASE + 32'h20; wdata = 32'hFF; we = 1'b1; re = 1'b1;
        #1 chk("t6_sel_outside", {31'h0, sel}, 32'h0);
        @(negedge clk);
        addr_ram = BASE + 32'h02;
        #1 chk("t6_sel_misaligned", {31'h0, sel}, 32'h0);
        @(negedge clk);
        we = 1'b0; re = 1'b0; addr_ram = 32'h0; wdata = 32'h0;
        chk("t6_no_valid", {31'h0, rdata_valid}, 32'h0);
        chk("t6_dout_kept", {24'h0, gpio_out}, 32'hFC);
        chk("t6_dir_kept", {24'h0, gpio_oe}, 32'h00);

        // Reset in the middle of a read: no valid, state cleared
        @(negedge clk);
        addr_ram = BASE; re = 1'b1; reset = 1'b1;
        @(negedge clk);
        re = 1'b0; addr_ram = 32'h0;
        chk("rst_no_valid", {31'h0, rdata_valid}, 32'h0);
        chk("rst_dout", {24'h0, gpio_out}, 32'h00);
        reset = 1'b0;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
